// File: rtl/sram_bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_bus_arbiter_pkg : FSM state codes and bus size codes                |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package sram_bus_arbiter_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_I_ADDR = 3'd1;
    localparam logic [2:0] ST_I_DATA = 3'd2;
    localparam logic [2:0] ST_D_ADDR = 3'd3;
    localparam logic [2:0] ST_D_DATA = 3'd4;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    function automatic logic is_addr_state(input logic [2:0] st);
        return (st == ST_I_ADDR) || (st == ST_D_ADDR);
    endfunction

    function automatic logic is_data_state(input logic [2:0] st);
        return (st == ST_I_DATA) || (st == ST_D_DATA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_bus_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_bus_arbiter_if : SRAM-like req/addr_ok/data_ok memory bus           |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface sram_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();

    logic          bus_req;
    logic          bus_wr;
    logic [1:0]    bus_size;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_addr_ok;
    logic          bus_data_ok;
    logic [DW-1:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_wr,
        output bus_size,
        output bus_addr,
        output bus_wdata,
        input  bus_addr_ok,
        input  bus_data_ok,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_wr,
        input  bus_size,
        input  bus_addr,
        input  bus_wdata,
        output bus_addr_ok,
        output bus_data_ok,
        output bus_rdata
    );

endinterface

`default_nettype wire

// File: rtl/sram_bus_arbiter_port_hold.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_bus_arbiter_port_hold : per-port done flag and read-data hold reg   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sram_bus_arbiter_port_hold #(
    parameter int DW = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          set_done,
    input  wire logic          capture,
    input  wire logic          pipe_stall,
    input  wire logic          flush,
    input  wire logic [DW-1:0] rdata_in,
    output logic               done,
    output logic [DW-1:0]      rdata
);

    logic          r_done;
    logic [DW-1:0] r_rdata;

    // A completion landing while the pipeline is frozen must survive that
    // edge; otherwise an advancing pipeline or a flush retires the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else if (set_done && pipe_stall) begin
            r_done <= 1'b1;
        end else if (!pipe_stall || flush) begin
            r_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (capture) begin
            r_rdata <= rdata_in;
        end
    end

    assign done  = r_done;
    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_bus_arbiter : shares one SRAM-like bus between IF and MEM ports     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          inst_req,
    input  wire logic [AW-1:0] inst_addr,
    output logic [DW-1:0]      inst_rdata,
    output logic               i_stall,
    input  wire logic          data_req,
    input  wire logic          data_wr,
    input  wire logic [1:0]    data_size,
    input  wire logic [AW-1:0] data_addr,
    input  wire logic [DW-1:0] data_wdata,
    output logic [DW-1:0]      data_rdata,
    output logic               d_stall,
    input  wire logic          pipe_stall,
    input  wire logic          flush,
    sram_bus_arbiter_if.master bus
);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic          r_discard;
    logic          w_discard_nxt;
    logic          r_bus_wr;
    logic [1:0]    r_bus_size;
    logic [AW-1:0] r_bus_addr;
    logic [DW-1:0] r_bus_wdata;
    logic          w_i_done;
    logic          w_d_done;
    logic          w_issue_i;
    logic          w_issue_d;
    logic          w_keep;
    logic          w_set_i;
    logic          w_set_d;

    assign i_stall = inst_req & ~w_i_done;
    assign d_stall = data_req & ~w_d_done;

    // Data wins ties: it belongs to the older instruction in the pipe.
    assign w_issue_d = (r_state == ST_IDLE) & d_stall & ~flush;
    assign w_issue_i = (r_state == ST_IDLE) & i_stall & ~flush & ~d_stall;

    // A response is kept only if no flush has hit the transaction.
    assign w_keep  = is_data_state(r_state) & bus.bus_data_ok & ~r_discard & ~flush;
    assign w_set_i = w_keep & (r_state == ST_I_DATA);
    assign w_set_d = w_keep & (r_state == ST_D_DATA);

    always_comb begin
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        case (r_state)
            ST_IDLE: begin
                if (w_issue_d) begin
                    w_state_nxt = ST_D_ADDR;
                end else if (w_issue_i) begin
                    w_state_nxt = ST_I_ADDR;
                end
            end
            ST_I_ADDR, ST_D_ADDR: begin
                if (bus.bus_addr_ok) begin
                    w_state_nxt = (r_state == ST_I_ADDR) ? ST_I_DATA : ST_D_DATA;
                    if (flush) begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_I_DATA, ST_D_DATA: begin
                if (bus.bus_data_ok) begin
                    w_state_nxt   = ST_IDLE;
                    w_discard_nxt = 1'b0;
                end else if (flush) begin
                    w_discard_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    // Payload is latched at issue so it stays put while the slave stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bus_wr    <= 1'b0;
            r_bus_size  <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else if (w_issue_d) begin
            r_bus_wr    <= data_wr;
            r_bus_size  <= data_size;
            r_bus_addr  <= data_addr;
            r_bus_wdata <= data_wdata;
        end else if (w_issue_i) begin
            r_bus_wr    <= 1'b0;
            r_bus_size  <= SIZE_W;
            r_bus_addr  <= inst_addr;
            r_bus_wdata <= '0;
        end
    end

    assign bus.bus_req   = is_addr_state(r_state);
    assign bus.bus_wr    = r_bus_wr;
    assign bus.bus_size  = r_bus_size;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;

    sram_bus_arbiter_port_hold #(
        .DW (DW)
    ) u_i_hold (
        .clk        (clk),
        .rst        (rst),
        .set_done   (w_set_i),
        .capture    (w_set_i),
        .pipe_stall (pipe_stall),
        .flush      (flush),
        .rdata_in   (bus.bus_rdata),
        .done       (w_i_done),
        .rdata      (inst_rdata)
    );

    // Stores complete the handshake but leave the load-data register alone.
    sram_bus_arbiter_port_hold #(
        .DW (DW)
    ) u_d_hold (
        .clk        (clk),
        .rst        (rst),
        .set_done   (w_set_d),
        .capture    (w_set_d & ~r_bus_wr),
        .pipe_stall (pipe_stall),
        .flush      (flush),
        .rdata_in   (bus.bus_rdata),
        .done       (w_d_done),
        .rdata      (data_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sram_bus_arbiter : vector table, corner sequences, random vs model    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_sram_bus_arbiter;
    import sram_bus_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;
    localparam logic [31:0] R1 = 32'h3C1D_0001;
    localparam logic [31:0] R2 = 32'h1122_3344;
    localparam logic [31:0] R3 = 32'h0000_0042;
    localparam logic [31:0] R4 = 32'h55AA_55AA;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_rdata;
    logic          i_stall;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          d_stall;
    logic          pipe_stall;
    logic          flush;

    sram_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

    sram_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .i_stall    (i_stall),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_size  (data_size),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .d_stall    (d_stall),
        .pipe_stall (pipe_stall),
        .flush      (flush),
        .bus        (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ir, dr, wr, ps, fl, aok, dok;
        logic [31:0] rdata;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eis, eds;
        logic [31:0] eir, edr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic ir, dr, wr, ps, fl, aok, dok, input logic [31:0] rdata,
                               input logic ereq, input logic [31:0] eaddr, input logic eis, eds,
                               input logic [31:0] eir, edr);
        vec_t t;
        t.ir = ir; t.dr = dr; t.wr = wr; t.ps = ps; t.fl = fl; t.aok = aok; t.dok = dok;
        t.rdata = rdata; t.ereq = ereq; t.eaddr = eaddr;
        t.eis = eis; t.eds = eds; t.eir = eir; t.edr = edr;
        return t;
    endfunction

    // reference model: transaction phase 0 none, 1 awaiting accept, 2 awaiting response
    int          m_phase;
    logic        m_port_d, m_disc, m_idone, m_ddone;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
    logic        slv_pending;

    task automatic model_reset();
        m_phase = 0; m_port_d = 1'b0; m_disc = 1'b0; m_idone = 1'b0; m_ddone = 1'b0;
        m_wr = 1'b0; m_size = '0; m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
        slv_pending = 1'b0;
    endtask

    task automatic model_step();
        logic want_i, want_d, fin_i, fin_d;
        want_i = inst_req & ~m_idone;
        want_d = data_req & ~m_ddone;
        fin_i = 1'b0;
        fin_d = 1'b0;
        if (m_phase == 0) begin
            if (want_d && !flush) begin
                m_phase = 1; m_port_d = 1'b1; m_wr = data_wr; m_size = data_size;
                m_addr = data_addr; m_wdata = data_wdata;
            end else if (want_i && !flush) begin
                m_phase = 1; m_port_d = 1'b0; m_wr = 1'b0; m_size = SIZE_W; m_addr = inst_addr;
            end
        end else if (m_phase == 1) begin
            if (bus_if.bus_addr_ok) begin
                m_phase = 2;
                if (flush) m_disc = 1'b1;
            end else if (flush) begin
                m_phase = 0;
            end
        end else begin
            if (bus_if.bus_data_ok) begin
                m_phase = 0;
                if (m_disc) m_disc = 1'b0;
                else if (!flush) begin
                    if (m_port_d) fin_d = 1'b1;
                    else fin_i = 1'b1;
                end
            end else if (flush) begin
                m_disc = 1'b1;
            end
        end
        if (fin_i) m_irdata = bus_if.bus_rdata;
        if (fin_d && !m_wr) m_drdata = bus_if.bus_rdata;
        if (!pipe_stall || flush) begin
            m_idone = 1'b0;
            m_ddone = 1'b0;
        end
        if (fin_i && pipe_stall) m_idone = 1'b1;
        if (fin_d && pipe_stall) m_ddone = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        inst_req = 1'b1; inst_addr = IA; data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_W;
        data_addr = DA; data_wdata = '0; pipe_stall = 1'b1; flush = 1'b0;
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        check("rst.bus_req", 32'(bus_if.bus_req), 32'd0);
        check("rst.bus_addr", bus_if.bus_addr, 32'd0);
        check("rst.inst_rdata", inst_rdata, 32'd0);
        check("rst.data_rdata", data_rdata, 32'd0);
        check("rst.i_stall", 32'(i_stall), 32'd1);
        check("rst.d_stall", 32'(d_stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //            ir dr wr ps fl ao do rdata         req addr  is ds  ir_data edata
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 1, 0, 32'h0, 32'h0));
        tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 32'h0,        1, IA,    1, 0, 32'h0, 32'h0));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, R1,           0, 32'h0, 1, 0, 32'h0, 32'h0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, R1,    32'h0));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, R1,    32'h0));
        tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 1, 1, R1,    32'h0));
        tbl.push_back(v(1, 1, 0, 1, 0, 1, 0, 32'h0,        1, DA,    1, 1, R1,    32'h0));
        tbl.push_back(v(1, 1, 0, 1, 0, 0, 1, R2,           0, 32'h0, 1, 1, R1,    32'h0));
        tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 1, 0, R1,    R2));
        tbl.push_back(v(1, 1, 0, 1, 0, 1, 0, 32'h0,        1, IA,    1, 0, R1,    R2));
        tbl.push_back(v(1, 1, 0, 1, 0, 0, 1, R3,           0, 32'h0, 1, 0, R1,    R2));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(1, 1, 0, 1, 0, 0, 0, 32'h0,    0, 32'h0, 0, 0, R3,    R2));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, R3,    R2));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, R3,    R2));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 1, 0, R3,    R2));
        tbl.push_back(v(1, 0, 0, 1, 1, 0, 0, 32'h0,        1, IA,    1, 0, R3,    R2));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, R3,    R2));
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 0, 1, R3,    R2));
        tbl.push_back(v(0, 1, 0, 1, 0, 1, 0, 32'h0,        1, DA,    0, 1, R3,    R2));
        tbl.push_back(v(0, 1, 0, 1, 1, 0, 0, 32'h0,        0, 32'h0, 0, 1, R3,    R2));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 32'hDEADBEEF, 0, 32'h0, 0, 0, R3,    R2));
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 0, 1, R3,    R2));
        tbl.push_back(v(0, 1, 0, 1, 0, 1, 0, 32'h0,        1, DA,    0, 1, R3,    R2));
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 1, R4,           0, 32'h0, 0, 1, R3,    R2));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, R3,    R4));
        tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 32'h0,        0, 32'h0, 0, 0, R3,    R4));

        for (int k = 0; k < tbl.size(); k++) begin
            inst_req = tbl[k].ir; data_req = tbl[k].dr; data_wr = tbl[k].wr;
            pipe_stall = tbl[k].ps; flush = tbl[k].fl;
            bus_if.bus_addr_ok = tbl[k].aok; bus_if.bus_data_ok = tbl[k].dok;
            bus_if.bus_rdata = tbl[k].rdata;
            @(negedge clk);
            check($sformatf("v%0d.bus_req", k), 32'(bus_if.bus_req), 32'(tbl[k].ereq));
            check($sformatf("v%0d.i_stall", k), 32'(i_stall), 32'(tbl[k].eis));
            check($sformatf("v%0d.d_stall", k), 32'(d_stall), 32'(tbl[k].eds));
            check($sformatf("v%0d.inst_rdata", k), inst_rdata, tbl[k].eir);
            check($sformatf("v%0d.data_rdata", k), data_rdata, tbl[k].edr);
            if (tbl[k].ereq) begin
                check($sformatf("v%0d.bus_addr", k), bus_if.bus_addr, tbl[k].eaddr);
                check($sformatf("v%0d.bus_wr", k), 32'(bus_if.bus_wr), 32'd0);
            end
            @(posedge clk);
            #1;
        end

        // byte store with the slave refusing the address phase for 4 cycles
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b0;
        data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_B;
        data_addr = 32'h8000_2003; data_wdata = 32'h0000_00AB; pipe_stall = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            data_addr = $urandom; data_wdata = $urandom; data_size = 2'($urandom_range(0, 2));
            @(negedge clk);
            check($sformatf("hold%0d.bus_req", i), 32'(bus_if.bus_req), 32'd1);
            check($sformatf("hold%0d.bus_addr", i), bus_if.bus_addr, 32'h8000_2003);
            check($sformatf("hold%0d.bus_wdata", i), bus_if.bus_wdata, 32'h0000_00AB);
            check($sformatf("hold%0d.bus_wr", i), 32'(bus_if.bus_wr), 32'd1);
            check($sformatf("hold%0d.bus_size", i), 32'(bus_if.bus_size), 32'(SIZE_B));
            tick();
        end
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("sw.data_req_phase", 32'(bus_if.bus_req), 32'd0);
        tick();
        bus_if.bus_data_ok = 1'b0;
        @(negedge clk);
        check("sw.d_stall", 32'(d_stall), 32'd0);
        check("sw.data_rdata", data_rdata, R4);
        pipe_stall = 1'b0;
        tick();
        data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_W; data_addr = DA; pipe_stall = 1'b1;
        tick();

        // async reset in the middle of a load response wait
        inst_req = 1'b1; bus_if.bus_addr_ok = 1'b1;
        tick();
        tick();
        bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h0BAD_F00D;
        tick();
        bus_if.bus_data_ok = 1'b0; data_req = 1'b1;
        tick();
        tick();
        bus_if.bus_addr_ok = 1'b0;
        @(negedge clk);
        check("pre_rst.i_stall", 32'(i_stall), 32'd0);
        check("pre_rst.inst_rdata", inst_rdata, 32'h0BAD_F00D);
        #2;
        rst = 1'b1;
        #1;
        check("arst.bus_req", 32'(bus_if.bus_req), 32'd0);
        check("arst.i_stall", 32'(i_stall), 32'd1);
        check("arst.d_stall", 32'(d_stall), 32'd1);
        check("arst.inst_rdata", inst_rdata, 32'd0);
        tick();
        rst = 1'b0; inst_req = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst.bus_req", 32'(bus_if.bus_req), 32'd1);
        check("post_rst.bus_addr", bus_if.bus_addr, DA);

        // randomized traffic against the reference model
        rst = 1'b1; data_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic exp_req;
            inst_req = ($urandom % 4) != 0;
            data_req = ($urandom % 3) == 0;
            data_wr = 1'($urandom);
            data_size = 2'($urandom_range(0, 2));
            inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
            pipe_stall = ($urandom % 4) != 0;
            flush = ($urandom % 10) == 0;
            bus_if.bus_addr_ok = 1'($urandom);
            bus_if.bus_data_ok = slv_pending && 1'($urandom);
            bus_if.bus_rdata = $urandom;
            @(negedge clk);
            exp_req = (m_phase == 1);
            check("rnd.i_stall", 32'(i_stall), 32'(inst_req & ~m_idone));
            check("rnd.d_stall", 32'(d_stall), 32'(data_req & ~m_ddone));
            check("rnd.bus_req", 32'(bus_if.bus_req), 32'(exp_req));
            check("rnd.inst_rdata", inst_rdata, m_irdata);
            check("rnd.data_rdata", data_rdata, m_drdata);
            if (exp_req) begin
                check("rnd.bus_addr", bus_if.bus_addr, m_addr);
                check("rnd.bus_wr", 32'(bus_if.bus_wr), 32'(m_wr));
                check("rnd.bus_size", 32'(bus_if.bus_size), 32'(m_size));
                if (m_wr) check("rnd.bus_wdata", bus_if.bus_wdata, m_wdata);
            end
            model_step();
            if (bus_if.bus_data_ok) slv_pending = 1'b0;
            if (bus_if.bus_req && bus_if.bus_addr_ok) slv_pending = 1'b1;
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
